// File: rtl/ooo_pkg.sv
// Shared out-of-order core constants: datapath width, physical register count
// and the physical register index type.
package ooo_pkg;
  localparam int XLEN      = 32;
  localparam int NUM_PREGS = 128;
  localparam int PW        = $clog2(NUM_PREGS);
  typedef logic [PW-1:0] preg_t;
endpackage

// File: rtl/prf_wr_arbiter.sv
// Per-register write select: for every physical register, report whether any
// write port targets it and which port wins (lowest-numbered port has priority).
module prf_wr_arbiter #(
  parameter  int NUM_PREGS = ooo_pkg::NUM_PREGS,
  parameter  int NUM_WR    = 3,
  localparam int PW        = $clog2(NUM_PREGS),
  localparam int WW        = (NUM_WR > 1) ? $clog2(NUM_WR) : 1
) (
  input  logic [NUM_WR-1:0]       wr_en_i,
  input  logic [NUM_WR*PW-1:0]    wr_pd_i,
  output logic [NUM_PREGS-1:0]    sel_en_o,
  output logic [NUM_PREGS*WW-1:0] sel_port_o
);

  // Register 0 is hardwired to zero, so it never gets a select.
  always_comb begin
    sel_en_o   = '0;
    sel_port_o = '0;
    for (int r = 1; r < NUM_PREGS; r++) begin
      for (int p = NUM_WR - 1; p >= 0; p--) begin
        if (wr_en_i[p] && (wr_pd_i[p*PW +: PW] == PW'(r))) begin
          sel_en_o[r]            = 1'b1;
          sel_port_o[r*WW +: WW] = WW'(p);
        end
      end
    end
  end

endmodule

// File: rtl/prf_multiport.sv
// Multi-ported physical register file with write-before-read bypass,
// per-register ready bits and a single registered read stage per port.
module prf_multiport #(
  parameter  int NUM_PREGS = ooo_pkg::NUM_PREGS,
  parameter  int XLEN      = ooo_pkg::XLEN,
  parameter  int NUM_WR    = 3,
  parameter  int NUM_RD    = 3,
  localparam int PW        = $clog2(NUM_PREGS),
  localparam int WW        = (NUM_WR > 1) ? $clog2(NUM_WR) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_WR-1:0]      wr_en,
  input  logic [NUM_WR*PW-1:0]   wr_pd,
  input  logic [NUM_WR*XLEN-1:0] wr_data,
  input  logic [NUM_RD-1:0]      rd_en,
  input  logic [NUM_RD*PW-1:0]   rd_ps1,
  input  logic [NUM_RD*PW-1:0]   rd_ps2,
  output logic [NUM_RD-1:0]      rd_valid,
  output logic [NUM_RD*XLEN-1:0] rd_data1,
  output logic [NUM_RD*XLEN-1:0] rd_data2,
  input  logic                   alloc_en,
  input  logic [PW-1:0]          alloc_pd,
  input  logic                   flush,
  output logic [NUM_PREGS-1:0]   ready_vec
);

  logic [XLEN-1:0]        arr_q [NUM_PREGS];
  logic [XLEN-1:0]        wdata [NUM_PREGS];
  logic [NUM_PREGS-1:0]   sel_en;
  logic [NUM_PREGS*WW-1:0] sel_port;
  logic [NUM_PREGS-1:0]   ready_q, ready_d;
  logic [NUM_RD-1:0]      rd_valid_q, rd_valid_d;
  logic [NUM_RD*XLEN-1:0] rd_data1_q, rd_data1_d;
  logic [NUM_RD*XLEN-1:0] rd_data2_q, rd_data2_d;

  prf_wr_arbiter #(
    .NUM_PREGS (NUM_PREGS),
    .NUM_WR    (NUM_WR)
  ) u_arb (
    .wr_en_i    (wr_en),
    .wr_pd_i    (wr_pd),
    .sel_en_o   (sel_en),
    .sel_port_o (sel_port)
  );

  always_comb begin
    for (int r = 0; r < NUM_PREGS; r++) begin
      wdata[r] = '0;
      for (int p = 0; p < NUM_WR; p++) begin
        if (sel_port[r*WW +: WW] == WW'(p)) wdata[r] = wr_data[p*XLEN +: XLEN];
      end
    end
  end

  // Same-cycle write data takes precedence over the stored value.
  function automatic logic [XLEN-1:0] lookup(input logic [PW-1:0] ps);
    if (ps == '0)       return '0;
    else if (sel_en[ps]) return wdata[ps];
    else                 return arr_q[ps];
  endfunction

  always_comb begin
    rd_valid_d = rd_en & ~{NUM_RD{flush}};
    rd_data1_d = rd_data1_q;
    rd_data2_d = rd_data2_q;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_valid_d[i]) begin
        rd_data1_d[i*XLEN +: XLEN] = lookup(rd_ps1[i*PW +: PW]);
        rd_data2_d[i*XLEN +: XLEN] = lookup(rd_ps2[i*PW +: PW]);
      end
    end
  end

  // Allocation overrides a coincident write's ready-set.
  always_comb begin
    ready_d = ready_q | sel_en;
    if (alloc_en && (alloc_pd != '0)) ready_d[alloc_pd] = 1'b0;
    ready_d[0] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_PREGS; r++) arr_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_PREGS; r++) begin
        if (sel_en[r]) arr_q[r] <= wdata[r];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q    <= '1;
      rd_valid_q <= '0;
      rd_data1_q <= '0;
      rd_data2_q <= '0;
    end else begin
      ready_q    <= ready_d;
      rd_valid_q <= rd_valid_d;
      rd_data1_q <= rd_data1_d;
      rd_data2_q <= rd_data2_d;
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_data1  = rd_data1_q;
  assign rd_data2  = rd_data2_q;
  assign ready_vec = ready_q;

endmodule

// File: tb/tb_prf_multiport.sv
// Randomized bench for prf_multiport against an array-based reference model.
module tb_prf_multiport;
  localparam int NP = 128;
  localparam int XL = 32;
  localparam int NW = 3;
  localparam int NR = 3;
  localparam int PW = 7;

  logic            clk = 1'b0;
  logic            reset;
  logic [NW-1:0]   wr_en;
  logic [NW*PW-1:0] wr_pd;
  logic [NW*XL-1:0] wr_data;
  logic [NR-1:0]   rd_en;
  logic [NR*PW-1:0] rd_ps1, rd_ps2;
  logic [NR-1:0]   rd_valid;
  logic [NR*XL-1:0] rd_data1, rd_data2;
  logic            alloc_en;
  logic [PW-1:0]   alloc_pd;
  logic            flush;
  logic [NP-1:0]   ready_vec;

  prf_multiport #(.NUM_PREGS(NP), .XLEN(XL), .NUM_WR(NW), .NUM_RD(NR)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_pd(wr_pd), .wr_data(wr_data),
    .rd_en(rd_en), .rd_ps1(rd_ps1), .rd_ps2(rd_ps2), .rd_valid(rd_valid),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .alloc_en(alloc_en),
    .alloc_pd(alloc_pd), .flush(flush), .ready_vec(ready_vec)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [XL-1:0] m_mem [NP];
  logic [NP-1:0] m_rdy;
  logic [NR-1:0] m_vld;
  logic [XL-1:0] m_d1 [NR];
  logic [XL-1:0] m_d2 [NR];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NP; r++) m_mem[r] = '0;
    m_rdy = '1;
    m_vld = '0;
    for (int i = 0; i < NR; i++) begin
      m_d1[i] = '0;
      m_d2[i] = '0;
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < NR; i++) begin
      check($sformatf("rd_valid[%0d]", i), 128'(rd_valid[i]), 128'(m_vld[i]));
      check($sformatf("rd_data1[%0d]", i), 128'(rd_data1[i*XL +: XL]), 128'(m_d1[i]));
      check($sformatf("rd_data2[%0d]", i), 128'(rd_data2[i*XL +: XL]), 128'(m_d2[i]));
    end
    check("ready_vec", 128'(ready_vec), 128'(m_rdy));
  endtask

  task automatic idle();
    wr_en = '0; wr_pd = '0; wr_data = '0;
    rd_en = '0; rd_ps1 = '0; rd_ps2 = '0;
    alloc_en = 1'b0; alloc_pd = '0; flush = 1'b0;
  endtask

  // One clock: predict from the current inputs, clock, then compare.
  task automatic step();
    logic [XL-1:0] nm [NP];
    logic [PW-1:0] pd;
    nm = m_mem;
    for (int p = NW - 1; p >= 0; p--) begin
      pd = wr_pd[p*PW +: PW];
      if (wr_en[p] && pd != 0) nm[pd] = wr_data[p*XL +: XL];
    end
    for (int i = 0; i < NR; i++) begin
      if (rd_en[i] && !flush) begin
        m_vld[i] = 1'b1;
        m_d1[i]  = nm[rd_ps1[i*PW +: PW]];
        m_d2[i]  = nm[rd_ps2[i*PW +: PW]];
      end else begin
        m_vld[i] = 1'b0;
      end
    end
    for (int p = 0; p < NW; p++) begin
      pd = wr_pd[p*PW +: PW];
      if (wr_en[p] && pd != 0) m_rdy[pd] = 1'b1;
    end
    if (alloc_en && alloc_pd != 0) m_rdy[alloc_pd] = 1'b0;
    m_mem = nm;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic set_wr(input int p, input int pd, input logic [XL-1:0] d);
    wr_en[p] = 1'b1;
    wr_pd[p*PW +: PW] = PW'(pd);
    wr_data[p*XL +: XL] = d;
  endtask

  task automatic set_rd(input int i, input int ps1, input int ps2);
    rd_en[i] = 1'b1;
    rd_ps1[i*PW +: PW] = PW'(ps1);
    rd_ps2[i*PW +: PW] = PW'(ps2);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Write-before-read bypass on a different port
    idle(); set_wr(0, 5, 32'hDEAD_BEEF); set_rd(1, 5, 0);
    step();
    check("bypass_deadbeef", 128'(rd_data1[1*XL +: XL]), 128'(32'hDEAD_BEEF));
    check("bypass_valid", 128'(rd_valid[1]), 128'(1'b1));

    // Port priority on a shared destination, bypass and array
    idle(); set_wr(0, 9, 32'h11); set_wr(2, 9, 32'h22); set_rd(2, 0, 9);
    step();
    check("prio_bypass", 128'(rd_data2[2*XL +: XL]), 128'(32'h11));
    idle(); set_rd(0, 0, 9);
    step();
    check("prio_array", 128'(rd_data2[0*XL +: XL]), 128'(32'h11));

    // Register zero is immutable
    idle(); set_wr(1, 0, 32'hFFFF_FFFF); set_rd(0, 0, 0); alloc_en = 1'b1; alloc_pd = '0;
    step();
    idle(); set_rd(2, 0, 0);
    step();
    check("r0_read", 128'(rd_data1[2*XL +: XL]), 128'(0));
    check("r0_ready", 128'(ready_vec[0]), 128'(1'b1));

    // Ready tracking through alloc, write, and alloc+write
    idle(); alloc_en = 1'b1; alloc_pd = PW'(12);
    step();
    check("alloc_clears", 128'(ready_vec[12]), 128'(1'b0));
    idle(); step(); step();
    set_wr(1, 12, 32'h1234);
    step();
    check("write_sets", 128'(ready_vec[12]), 128'(1'b1));
    idle(); alloc_en = 1'b1; alloc_pd = PW'(12); set_wr(0, 12, 32'h5678);
    step();
    check("alloc_wins", 128'(ready_vec[12]), 128'(1'b0));
    idle(); set_rd(0, 12, 12);
    step();
    check("alloc_write_data", 128'(rd_data1[0*XL +: XL]), 128'(32'h5678));

    // Flush drops the read issued alongside it
    idle(); set_rd(0, 5, 9); flush = 1'b1;
    step();
    check("flush_drop", 128'(rd_valid[0]), 128'(1'b0));
    check("flush_hold", 128'(rd_data1[0*XL +: XL]), 128'(32'h5678));
    idle(); set_rd(0, 5, 9);
    step();
    check("after_flush", 128'(rd_valid[0]), 128'(1'b1));

    // Asynchronous reset in the middle of a cycle with a read outstanding
    idle(); set_wr(0, 7, 32'h5A); set_rd(0, 7, 5); set_rd(1, 5, 7);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("async_valid", 128'(rd_valid), 128'(0));
    check("async_ready", 128'(ready_vec), {128{1'b1}});
    check_outputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(); set_rd(0, 7, 5);
    step();
    check("post_reset_r7", 128'(rd_data1[0*XL +: XL]), 128'(0));

    // Randomized traffic with a bias toward colliding indices
    for (int c = 0; c < 400; c++) begin
      idle();
      for (int p = 0; p < NW; p++) begin
        if ($urandom_range(0, 1) == 1)
          set_wr(p, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(0, NP - 1), $urandom);
      end
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(0, 2) != 0)
          set_rd(i, $urandom_range(0, 15), ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(0, NP - 1));
      end
      alloc_en = ($urandom_range(0, 3) == 0);
      alloc_pd = PW'($urandom_range(0, 15));
      flush    = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prf_multiport.md
PRF_MULTIPORT -- requirements
Module: prf_multiport

Interface
REQ-001 Parameter: NUM_PREGS, 128, number of physical registers (power of two, >= 4).
REQ-002 Parameter: XLEN, 32, data width.
REQ-003 Parameter: NUM_WR, 3, writeback ports (FU channels).
REQ-004 Parameter: NUM_RD, 3, read ports, each with two source operands.
REQ-005 Localparam PW = $clog2(NUM_PREGS), physical register index width.
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 reset  in  1  reset, asynchronous, active-high.
REQ-008 wr_en  in  NUM_WR  per-port write strobe.
REQ-009 wr_pd  in  NUM_WR*PW  per-port destination register.
REQ-010 wr_data  in  NUM_WR*XLEN  per-port write data.
REQ-011 rd_en  in  NUM_RD  per-port read request.
REQ-012 rd_ps1, rd_ps2  in  NUM_RD*PW each  per-port source registers.
REQ-013 rd_valid  out  NUM_RD  registered read-data-valid.
REQ-014 rd_data1, rd_data2  out  NUM_RD*XLEN each  registered operand data.
REQ-015 alloc_en  in  1  rename allocated a destination register this cycle.
REQ-016 alloc_pd  in  PW  allocated register index.
REQ-017 flush  in  1  pipeline squash.
REQ-018 ready_vec  out  NUM_PREGS  per-register ready (value written) bits, registered.

Function
REQ-019 Reads: rd_en[i] high in cycle N -> rd_valid[i]=1 and rd_data1/2[i] in cycle N+1 (1-cycle latency); rd_en low -> rd_valid=0, data held at previous value.
REQ-020 Bypass: a write in cycle N to a register read in cycle N shall be returned by the read in N+1 (write-before-read).
REQ-021 Register 0 shall always read 0; writes and allocations to index 0 shall be ignored; ready_vec[0] always 1.
REQ-022 Multiple write ports targeting the same register in one cycle: the lowest-numbered port wins, for both array and bypass.
REQ-023 Write sets ready_vec[wr_pd] to 1 on the next edge.
REQ-024 alloc_en clears ready_vec[alloc_pd] on the next edge; alloc and write to same register in the same cycle -> alloc wins (ready=0), data still written.
REQ-025 flush: rd_valid forced to 0 in the following cycle regardless of rd_en; array and ready_vec unaffected; reads issued in the flush cycle are dropped.
REQ-026 Array contents shall change only via writes; out-of-range indices impossible (NUM_PREGS power of two).

Reset
REQ-027 On reset: all array entries 0, ready_vec all 1, rd_valid all 0, rd_data1/2 all 0.
REQ-028 Reset asserted mid-read: rd_valid goes 0 immediately (asynchronous); pending read discarded.
REQ-029 First reads after reset deassertion return 0 for every register.

Structure
REQ-030 Shared package ooo_pkg holds XLEN, NUM_PREGS, PW and a preg_t typedef; parameters default from it.
REQ-031 One sub-module prf_wr_arbiter: per-register priority write select (winning port, enable) used by array, bypass and ready logic.
REQ-032 Read path: combinational array+bypass lookup feeding one output register stage per port.

Verification
REQ-033 Write port0 pd=5 data=0xDEADBEEF cycle N; read port1 ps1=5 cycle N -> cycle N+1 rd_valid[1]=1, rd_data1[1]=0xDEADBEEF.
REQ-034 Ports 0 and 2 both write pd=9 (0x11, 0x22) same cycle; read ps2=9 next cycle -> 0x11.
REQ-035 Write pd=0 data=0xFFFF_FFFF; read ps1=0 -> 0; ready_vec[0]=1.
REQ-036 alloc_pd=12 cycle N -> ready_vec[12]=0 at N+1; write pd=12 at N+3 -> ready_vec[12]=1 at N+4; alloc+write pd=12 same cycle -> ready_vec[12]=0.
REQ-037 rd_en[0]=1 with flush=1 -> rd_valid[0]=0 next cycle; next read without flush -> rd_valid[0]=1.
REQ-038 Write pd=7 data=0x5A, assert reset mid-cycle -> rd_valid all 0 immediately, read pd=7 after release -> 0, ready_vec all ones.
